// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Sobel window state, pixel order and gradient weight tables
package sobel_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    localparam int NumPix = 8;

    // Neighbour arrival order; the centre pixel is never transferred
    localparam int unsigned PIX_TL = 0;
    localparam int unsigned PIX_T  = 1;
    localparam int unsigned PIX_TR = 2;
    localparam int unsigned PIX_L  = 3;
    localparam int unsigned PIX_R  = 4;
    localparam int unsigned PIX_BL = 5;
    localparam int unsigned PIX_B  = 6;
    localparam int unsigned PIX_BR = 7;

    localparam int GX_WEIGHT [NumPix] = '{-1, 0, 1, -2, 2, -1, 0, 1};
    localparam int GY_WEIGHT [NumPix] = '{-1, -2, -1, 0, 0, 1, 2, 1};

endpackage

// File: rtl/sobel_accumulator.sv
// rtl/sobel_accumulator.sv - streams 8 neighbours, accumulates Gx/Gy and emits magnitude
// Optional feature macro: SOBEL_THRESHOLD_EN (binary edge flag instead of saturated magnitude)
module sobel_accumulator
    import sobel_pkg::*;
#(
    parameter int PixWidth  = 8,
    parameter int Threshold = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pix_valid_i,
    output logic                       pix_ready_o,
    input  logic [PixWidth-1:0]        pix_data_i,
    input  logic                       abort_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic signed [PixWidth+2:0] res_gx_o,
    output logic signed [PixWidth+2:0] res_gy_o,
    output logic [PixWidth-1:0]        res_mag_o
);

    localparam int AccW = PixWidth + 3;
    localparam logic [PixWidth-1:0] MagMax = {PixWidth{1'b1}};

    state_t                 state, state_next;
    logic [2:0]             idx;
    logic signed [AccW-1:0] gx_acc, gy_acc;
    logic signed [AccW-1:0] pix_ext, gx_term, gy_term;
    logic [AccW-1:0]        gx_abs, gy_abs;
    logic [AccW:0]          mag_sum;
    logic                   pix_fire, res_fire, last_pix;

    // Weights are limited to 0, +-1, +-2, so a shift/negate replaces the multiplier
    function automatic logic signed [AccW-1:0] weigh(input int w, input logic signed [AccW-1:0] p);
        case (w)
            1:       return p;
            -1:      return -p;
            2:       return p <<< 1;
            -2:      return -(p <<< 1);
            default: return '0;
        endcase
    endfunction

    assign pix_ext  = signed'({3'b000, pix_data_i});
    assign gx_term  = weigh(GX_WEIGHT[idx], pix_ext);
    assign gy_term  = weigh(GY_WEIGHT[idx], pix_ext);
    assign pix_fire = pix_valid_i & pix_ready_o;
    assign res_fire = res_valid_o & res_ready_i;
    assign last_pix = (idx == 3'd7);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort_i) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (pix_fire && last_pix) state_next = RESULT;
                RESULT:  if (res_fire) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    always_comb begin
        pix_ready_o = (state == ACCUM);
        res_valid_o = (state == RESULT);
    end

    // Abort outranks both handshakes: the offered pixel or pending result is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx    <= '0;
            gx_acc <= '0;
            gy_acc <= '0;
        end else if (abort_i || res_fire) begin
            idx    <= '0;
            gx_acc <= '0;
            gy_acc <= '0;
        end else if (pix_fire) begin
            idx    <= idx + 3'd1;
            gx_acc <= gx_acc + gx_term;
            gy_acc <= gy_acc + gy_term;
        end
    end

    assign res_gx_o = gx_acc;
    assign res_gy_o = gy_acc;
    assign gx_abs   = gx_acc[AccW-1] ? unsigned'(-gx_acc) : unsigned'(gx_acc);
    assign gy_abs   = gy_acc[AccW-1] ? unsigned'(-gy_acc) : unsigned'(gy_acc);
    assign mag_sum  = {1'b0, gx_abs} + {1'b0, gy_abs};

`ifdef SOBEL_THRESHOLD_EN
    always_comb begin
        res_mag_o = (mag_sum > (AccW+1)'(Threshold)) ? MagMax : '0;
    end
`else
    logic unused_threshold;
    assign unused_threshold = (Threshold != 0);

    always_comb begin
        res_mag_o = (|mag_sum[AccW:PixWidth]) ? MagMax : mag_sum[PixWidth-1:0];
    end
`endif

endmodule

// File: tb/tb_sobel_accumulator.sv
// tb/tb_sobel_accumulator.sv - scoreboard bench for sobel_accumulator
module tb_sobel_accumulator;

    localparam int PW = 8;
    localparam int TH = 128;

    typedef struct packed {
        logic signed [10:0] gx;
        logic signed [10:0] gy;
        logic [7:0]         mag;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic [PW-1:0]     pix_data = '0;
    logic              abort = 1'b0;
    logic              res_ready = 1'b0;
    logic              pix_ready;
    logic              res_valid;
    logic signed [10:0] res_gx;
    logic signed [10:0] res_gy;
    logic [PW-1:0]     res_mag;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   win[8];
    int   wx[8] = '{-1, 0, 1, -2, 2, -1, 0, 1};
    int   wy[8] = '{-1, -2, -1, 0, 0, 1, 2, 1};

    sobel_accumulator #(.PixWidth(PW), .Threshold(TH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pix_valid_i(pix_valid),
        .pix_ready_o(pix_ready),
        .pix_data_i (pix_data),
        .abort_i    (abort),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .res_gx_o   (res_gx),
        .res_gy_o   (res_gy),
        .res_mag_o  (res_mag)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int gx, input int gy, input int mag_sat, input int mag_th);
        res_t r;
        r.gx = gx[10:0];
        r.gy = gy[10:0];
`ifdef SOBEL_THRESHOLD_EN
        r.mag = mag_th[7:0];
`else
        r.mag = mag_sat[7:0];
`endif
        exp_q.push_back(r);
    endtask

    task automatic push_model();
        int gx = 0;
        int gy = 0;
        int s;
        for (int i = 0; i < 8; i++) begin
            gx += wx[i] * win[i];
            gy += wy[i] * win[i];
        end
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        push_exp(gx, gy, (s > 255) ? 255 : s, (s > TH) ? 255 : 0);
    endtask

    // Starts and ends at a falling edge
    task automatic drive_pixel(input int v);
        int t = 0;
        pix_valid = 1'b1;
        pix_data  = v[PW-1:0];
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_timeout: pix_ready=%0b required 1", pix_ready);
        end
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic send_window();
        for (int i = 0; i < 8; i++) drive_pixel(win[i]);
    endtask

    task automatic get_result(input string name);
        res_t e;
        int t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: res_valid=%0b required 1", name, res_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: queue size=0 required >0", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (res_gx !== e.gx) begin
            errors++;
            $display("FAIL %s_gx: got %0d required %0d", name, res_gx, e.gx);
        end
        checks++;
        if (res_gy !== e.gy) begin
            errors++;
            $display("FAIL %s_gy: got %0d required %0d", name, res_gy, e.gy);
        end
        checks++;
        if (res_mag !== e.mag) begin
            errors++;
            $display("FAIL %s_mag: got %0d required %0d", name, res_mag, e.mag);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_return: valid=%0b ready=%0b required 0 1", name, res_valid, pix_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pix_ready, res_valid, res_gx, res_gy, res_mag} !== {1'b1, 1'b0, 11'd0, 11'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b gx=%0d gy=%0d mag=%0d required 1 0 0 0 0",
                     pix_ready, res_valid, res_gx, res_gy, res_mag);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat();
        for (int i = 0; i < 8; i++) win[i] = 100;
        push_exp(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive_pixel(win[i]);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flat_early_valid: res_valid=%0b required 0", res_valid);
        end
        drive_pixel(win[7]);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL flat_latency: res_valid=%0b required 1", res_valid);
        end
        get_result("flat");
    endtask

    task automatic test_single_tr();
        for (int i = 0; i < 8; i++) win[i] = 0;
        win[2] = 10;
        push_exp(10, -10, 20, 0);
        send_window();
        get_result("single_tr");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) win[i] = 0;
        win[2] = 255;
        win[4] = 255;
        win[7] = 255;
        push_exp(1020, 0, 255, 255);
        send_window();
        get_result("saturate");
    endtask

    task automatic test_backpressure();
        res_t e;
        win = '{50, 0, 12, 200, 3, 0, 30, 99};
        push_model();
        send_window();
        e = exp_q[0];
        pix_valid = 1'b1;
        pix_data  = 8'd200;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || pix_ready !== 1'b0 || res_gx !== e.gx
                || res_gy !== e.gy || res_mag !== e.mag) begin
                errors++;
                $display("FAIL backpressure_hold%0d: valid=%0b ready=%0b gx=%0d gy=%0d mag=%0d required 1 0 %0d %0d %0d",
                         c, res_valid, pix_ready, res_gx, res_gy, res_mag, e.gx, e.gy, e.mag);
            end
        end
        pix_valid = 1'b0;
        get_result("backpressure");
        win = '{7, 180, 33, 0, 255, 64, 1, 90};
        push_model();
        send_window();
        get_result("after_backpressure");
    endtask

    task automatic test_abort();
        drive_pixel(40);
        drive_pixel(0);
        drive_pixel(0);
        drive_pixel(90);
        abort     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'd250;
        @(posedge clk);
        @(negedge clk);
        abort     = 1'b0;
        pix_valid = 1'b0;
        checks++;
        if (pix_ready !== 1'b1 || res_valid !== 1'b0 || res_gx !== 11'sd0 || res_gy !== 11'sd0) begin
            errors++;
            $display("FAIL abort_clear: ready=%0b valid=%0b gx=%0d gy=%0d required 1 0 0 0",
                     pix_ready, res_valid, res_gx, res_gy);
        end
        for (int i = 0; i < 8; i++) win[i] = 0;
        push_exp(0, 0, 0, 0);
        send_window();
        get_result("abort_zero");
        win = '{0, 0, 10, 0, 0, 0, 0, 0};
        push_exp(10, -10, 20, 0);
        send_window();
        get_result("abort_align");
    endtask

    task automatic test_abort_result();
        int t = 0;
        win = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_window();
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        res_ready = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        abort     = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || pix_ready !== 1'b1 || res_gx !== 11'sd0) begin
            errors++;
            $display("FAIL abort_result: valid=%0b ready=%0b gx=%0d required 0 1 0", res_valid, pix_ready, res_gx);
        end
        win = '{255, 0, 0, 255, 0, 255, 0, 0};
        push_model();
        send_window();
        get_result("after_abort_result");
    endtask

    task automatic test_mid_reset();
        drive_pixel(200);
        drive_pixel(200);
        drive_pixel(200);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_ready, res_valid, res_gx, res_gy, res_mag} !== {1'b1, 1'b0, 11'd0, 11'd0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b valid=%0b gx=%0d gy=%0d mag=%0d required 1 0 0 0 0",
                     pix_ready, res_valid, res_gx, res_gy, res_mag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        win = '{0, 0, 255, 0, 255, 0, 0, 255};
        push_exp(1020, 0, 255, 255);
        send_window();
        get_result("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) win[i] = int'($urandom_range(0, 255));
            push_model();
            send_window();
            get_result("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_single_tr();
        test_saturate();
        test_backpressure();
        test_abort();
        test_abort_result();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: size=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
